// File: rtl/watch_pkg.sv
// Shared types and helpers for the stopwatch counter chain.
package watch_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  // Extract the modulus of digit idx from a packed 4-bit-per-digit list.
  function automatic logic [DIGIT_W-1:0] modulus_of(input logic [31:0] mod_list,
                                                    input int          idx);
    return mod_list[DIGIT_W*idx +: DIGIT_W];
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-N digit: clear, saturating parallel load, and up/down step with wrap.
module mod_n_digit
  import watch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               down,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_value,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] modulus,
  output logic [DIGIT_W-1:0] value,
  output logic               at_max,
  output logic               at_zero
);

  logic [DIGIT_W-1:0] value_q;
  logic [DIGIT_W-1:0] value_d;
  logic [DIGIT_W-1:0] max_value;

  assign max_value = modulus - DIGIT_W'(1);
  assign at_max    = (value_q == max_value);
  assign at_zero   = (value_q == '0);
  assign value     = value_q;

  // Next digit value: clear beats load beats step; loads above the top value saturate.
  always_comb begin
    // NOTE: default first so every path assigns value_d and no latch is inferred.
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      value_d = (load_value > max_value) ? max_value : load_value;
    end else if (step) begin
      if (down) value_d = at_zero ? max_value : value_q - DIGIT_W'(1);
      else      value_d = at_max  ? '0        : value_q + DIGIT_W'(1);
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

endmodule

// File: rtl/stopwatch_counter_chain.sv
// Multi-digit stopwatch: digit cascade, run/stop/expiry FSM, lap snapshot and event pulses.
module stopwatch_counter_chain
  import watch_pkg::*;
#(
  parameter int                    DIGITS   = 6,
  parameter logic [4*DIGITS-1:0]   MOD_LIST = 24'h6A6AAA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  mode_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow,
  output logic                  done
);

  localparam int CW = DIGIT_W * DIGITS;

  state_e            state_q, state_d;
  logic [CW-1:0]     snapshot_q, snapshot_d;
  logic              lap_active_q, lap_active_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] step;
  logic              all_max, all_zero;
  logic              count_en, load_en, wrap, expire;

  assign all_max  = &at_max;
  assign all_zero = &at_zero;

  // clear suppresses counting; load is only honoured while not running.
  assign count_en = tick && (state_q == RUNNING) && !clear;
  assign load_en  = load && !clear && (state_q != RUNNING);
  assign wrap     = count_en && !mode_down && all_max;
  assign expire   = count_en &&  mode_down && all_zero;

  // Carry chain: a digit steps when every lower digit sits at its wrap point.
  always_comb begin
    logic up_acc, dn_acc;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    step   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = count_en && (mode_down ? (dn_acc && !all_zero) : up_acc);
      up_acc  = up_acc && at_max[i];
      dn_acc  = dn_acc && at_zero[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod_n_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .step       (step[g]),
      .down       (mode_down),
      .load       (load_en),
      .load_value (load_value[DIGIT_W*g +: DIGIT_W]),
      .clear      (clear),
      .modulus    (modulus_of(32'(MOD_LIST), g)),
      .value      (count[DIGIT_W*g +: DIGIT_W]),
      .at_max     (at_max[g]),
      .at_zero    (at_zero[g])
    );
  end

  // Run-state transitions: clear > load > stop > start; expiry overrides a coincident stop.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = STOPPED;
    end else begin
      unique case (state_q)
        STOPPED: if (!load && !stop && start) state_d = RUNNING;
        RUNNING: begin
          if (expire)    state_d = EXPIRED;
          else if (stop) state_d = STOPPED;
        end
        EXPIRED: if (load) state_d = STOPPED;
        default: state_d = STOPPED;
      endcase
    end
  end

  // Lap toggle, snapshot capture of the pre-tick count, and one-cycle event pulses.
  always_comb begin
    lap_active_d = lap_active_q;
    snapshot_d   = snapshot_q;
    overflow_d   = wrap;
    done_d       = expire;
    if (clear) begin
      lap_active_d = 1'b0;
    end else if (lap) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (state_q == RUNNING) begin
        lap_active_d = 1'b1;
        snapshot_d   = count;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= STOPPED;
      snapshot_q   <= '0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snapshot_q   <= snapshot_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

  assign display    = lap_active_q ? snapshot_q : count;
  assign running    = (state_q == RUNNING);
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stopwatch_counter_chain.sv
// Self-checking bench: an integer-valued reference model feeds a scoreboard per cycle.
module tb_stopwatch_counter_chain;

  localparam int            DIGITS   = 6;
  localparam int            CW       = 4 * DIGITS;
  localparam logic [CW-1:0] MOD_LIST = 24'h6A6AAA;

  logic          clk = 1'b0;
  logic          reset, tick, start, stop, clear, mode_down, load, lap;
  logic [CW-1:0] load_value;
  logic [CW-1:0] count, display;
  logic          running, lap_active, overflow, done;

  stopwatch_counter_chain #(.DIGITS(DIGITS), .MOD_LIST(MOD_LIST)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .mode_down  (mode_down),
    .load       (load),
    .load_value (load_value),
    .lap        (lap),
    .count      (count),
    .display    (display),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] count;
    logic [CW-1:0] display;
    logic          running;
    logic          lap_active;
    logic          overflow;
    logic          done;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the count is held as one integer in mixed radix.
  int            m_mod[DIGITS];
  int            m_total;
  int            m_val;
  int            m_state;  // 0 stopped, 1 running, 2 expired
  logic          m_lap;
  logic [CW-1:0] m_snap;
  logic          md_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] enc(input int v);
    logic [CW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % m_mod[i]);
      x           = x / m_mod[i];
    end
    return r;
  endfunction

  function automatic int dec_sat(input logic [CW-1:0] lv);
    int v, w, d;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d >= m_mod[i]) d = m_mod[i] - 1;
      v += d * w;
      w *= m_mod[i];
    end
    return v;
  endfunction

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic cycle(input logic t, input logic st, input logic sp, input logic cl,
                       input logic ld, input logic [CW-1:0] lv, input logic lp);
    int            nv;
    int            ns;
    logic          nl, ovf, dn, cnt;
    logic [CW-1:0] nsnap;
    exp_t          e;
    tick = t; start = st; stop = sp; clear = cl; mode_down = md_sel;
    load = ld; load_value = lv; lap = lp;
    nv = m_val; ns = m_state; nl = m_lap; nsnap = m_snap; ovf = 1'b0; dn = 1'b0;
    cnt = t && (m_state == 1) && !cl;
    if (cl) begin
      nv = 0; ns = 0; nl = 1'b0;
    end else begin
      if (lp) begin
        if (m_lap) nl = 1'b0;
        else if (m_state == 1) begin nl = 1'b1; nsnap = enc(m_val); end
      end
      if (m_state != 1 && ld) begin
        nv = dec_sat(lv); ns = 0;
      end else begin
        if (m_state == 0 && !sp && st) ns = 1;
        if (m_state == 1 && sp) ns = 0;
        if (cnt) begin
          if (md_sel) begin
            if (m_val == 0) begin dn = 1'b1; ns = 2; end
            else nv = m_val - 1;
          end else begin
            if (m_val == m_total - 1) begin nv = 0; ovf = 1'b1; end
            else nv = m_val + 1;
          end
        end
      end
    end
    e.count      = enc(nv);
    e.display    = nl ? nsnap : enc(nv);
    e.running    = (ns == 1);
    e.lap_active = nl;
    e.overflow   = ovf;
    e.done       = dn;
    sb_q.push_back(e);
    m_val = nv; m_state = ns; m_lap = nl; m_snap = nsnap;

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("count",      32'(count),      32'(e.count));
    check("display",    32'(display),    32'(e.display));
    check("running",    32'(running),    32'(e.running));
    check("lap_active", 32'(lap_active), 32'(e.lap_active));
    check("overflow",   32'(overflow),   32'(e.overflow));
    check("done",       32'(done),       32'(e.done));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic do_start();        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0); endtask
  task automatic do_stop();         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0); endtask
  task automatic do_clear();        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0); endtask
  task automatic do_lap();          cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1); endtask
  task automatic do_load(input logic [CW-1:0] v); cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v, 1'b0); endtask

  initial begin
    logic [CW-1:0] ml;
    ml = MOD_LIST;
    m_total = 1;
    for (int i = 0; i < DIGITS; i++) begin
      m_mod[i] = int'(ml[4*i +: 4]);
      m_total *= m_mod[i];
    end
    md_sel = 1'b0;
    reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    mode_down = 1'b0; load = 1'b0; load_value = '0; lap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_val = 0; m_state = 0; m_lap = 1'b0; m_snap = '0;
    check("rst_count",    32'(count),      32'h0);
    check("rst_display",  32'(display),    32'h0);
    check("rst_running",  32'(running),    32'h0);
    check("rst_lap",      32'(lap_active), 32'h0);
    check("rst_overflow", 32'(overflow),   32'h0);
    check("rst_done",     32'(done),       32'h0);

    // 100 ticks of centiseconds -> one second.
    do_start();
    ticks(100);
    check("tp1_count",   32'(count),   32'h000100);
    check("tp1_running", 32'(running), 32'h1);

    // Full-chain wrap.
    do_stop();
    do_load(24'h595999);
    do_start();
    ticks(1);
    check("tp2_count",    32'(count),    32'h0);
    check("tp2_overflow", 32'(overflow), 32'h1);
    check("tp2_running",  32'(running),  32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("tp2_ovf_drop", 32'(overflow), 32'h0);

    // Countdown to expiry.
    do_stop();
    md_sel = 1'b1;
    do_load(24'h000002);
    do_start();
    ticks(1);
    check("tp3_cnt1", 32'(count), 32'h000001);
    ticks(1);
    check("tp3_cnt0", 32'(count), 32'h000000);
    check("tp3_nodone", 32'(done), 32'h0);
    ticks(1);
    check("tp3_done",    32'(done),    32'h1);
    check("tp3_running", 32'(running), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("tp3_hold",     32'(count),   32'h0);
    check("tp3_expired",  32'(running), 32'h0);
    do_clear();

    // Lap freeze.
    md_sel = 1'b0;
    do_start();
    ticks(42);
    check("tp4_count42", 32'(count), 32'h000042);
    do_lap();
    ticks(10);
    check("tp4_frozen", 32'(display), 32'h000042);
    check("tp4_live",   32'(count),   32'h000052);
    do_lap();
    check("tp4_release", 32'(display),    32'h000052);
    check("tp4_lap_off", 32'(lap_active), 32'h0);

    // start+stop together, then stop coincident with a tick.
    do_stop();
    do_clear();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("tp5_startstop", 32'(running), 32'h0);
    do_start();
    ticks(9);
    check("tp5_count9", 32'(count), 32'h000009);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("tp5_count10", 32'(count),   32'h000010);
    check("tp5_stopped", 32'(running), 32'h0);

    // Saturating load, then clear mid-run with lap active.
    do_load(24'hFFFFFF);
    check("tp6_sat", 32'(count), 32'h595999);
    do_start();
    do_lap();
    ticks(3);
    do_clear();
    check("tp6_clr_count",   32'(count),      32'h0);
    check("tp6_clr_lap",     32'(lap_active), 32'h0);
    check("tp6_clr_running", 32'(running),    32'h0);

    // Random control mix against the model.
    for (int i = 0; i < 400; i++) begin
      logic [CW-1:0] lv;
      if ($urandom_range(0, 29) == 0) md_sel = ~md_sel;
      lv = ($urandom_range(0, 1) == 0) ? CW'($urandom()) : enc(int'($urandom_range(0, 20)));
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 11) == 0),
            lv,
            1'($urandom_range(0, 11) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
